efp_add_seq: RTL and testbench

Parametrised, multi-cycle successor to the variable-precision floating-point adder driven from the VIO test harness. It adds or subtracts two operands in the team's extended-FP format: a sign bit, an EXP_W exponent, and a fraction field whose valid bit count is given per operand. Operands are accepted over a valid/ready handshake. Alignment and normalisation run one bit-shift per cycle, and each result reports the cycle count it consumed.

---
 rtl/efp_add_seq_if.sv | 47 ++++
 rtl/efp_add_seq.sv | 190 +++++++++++++++++++
 tb/tb_efp_add_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/efp_add_seq_if.sv
// efp_add_seq_if: operand / result bus for the sequential extended-FP adder.
//   master side (producer/consumer): drives in_valid, op_a, op_b, m_bit_a,
//     m_bit_b, sub, out_ready; observes in_ready and all result signals.
//   slave side (adder): the reverse.
//   op_a/op_b        {sign, exp[EXP_W], frac[FRAC_W]}, frac right-aligned
//   m_bit_a/m_bit_b  valid fraction bits per operand (clamped to FRAC_W)
//   result_*         sign, biased exponent, right-aligned fraction
//   output_m_bits    fraction width of the result
//   result_bias      constant exponent bias
//   time_period      cycles from accept to out_valid
//   overflow/underflow status flags
interface efp_add_seq_if #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 19,
  parameter int MB_W   = 5,
  parameter int TIME_W = 19
);
  logic                    in_valid;
  logic                    in_ready;
  logic [EXP_W+FRAC_W:0]   op_a;
  logic [EXP_W+FRAC_W:0]   op_b;
  logic [MB_W-1:0]         m_bit_a;
  logic [MB_W-1:0]         m_bit_b;
  logic                    sub;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sign_result;
  logic [EXP_W-1:0]        result_exp;
  logic [FRAC_W-1:0]       result_man;
  logic [MB_W-1:0]         output_m_bits;
  logic [4:0]              result_bias;
  logic [TIME_W-1:0]       time_period;
  logic                    overflow;
  logic                    underflow;

  modport master (
    output in_valid, op_a, op_b, m_bit_a, m_bit_b, sub, out_ready,
    input  in_ready, out_valid, sign_result, result_exp, result_man,
           output_m_bits, result_bias, time_period, overflow, underflow
  );

  modport slave (
    input  in_valid, op_a, op_b, m_bit_a, m_bit_b, sub, out_ready,
    output in_ready, out_valid, sign_result, result_exp, result_man,
           output_m_bits, result_bias, time_period, overflow, underflow
  );
endinterface

// File: rtl/efp_add_seq.sv
// efp_add_seq: multi-cycle adder/subtractor for the extended-FP format.
// Alignment and normalisation move one bit per cycle; each result carries
// the number of cycles it took.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  efp_add_seq_if slave: valid/ready operand input, valid/ready result
module efp_add_seq #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 19,
  parameter int MB_W   = 5,
  parameter int TIME_W = 19,
  parameter int G      = 2
) (
  input logic           clk,
  input logic           rst,
  efp_add_seq_if.slave  bus
);

  localparam int OPW = 1 + EXP_W + FRAC_W;
  localparam int MW = 1 + FRAC_W + G;
  localparam int ZERO_LIM = FRAC_W + G + 1;
  localparam logic [MB_W-1:0] FRAC_MB = MB_W'(FRAC_W);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, ADD, NORM, DONE} state_t;

  state_t state, next_state;

  logic              sign_a, sign_b, sign_r;
  logic [EXP_W-1:0]  exp_a, exp_b, exp_r, d;
  logic [MW-1:0]     man_a, man_b;
  logic [MW:0]       sum;
  logic [MB_W-1:0]   out_m;
  logic [TIME_W-1:0] cnt;

  logic              sign_q, ovf_q, unf_q;
  logic [EXP_W-1:0]  exp_q;
  logic [FRAC_W-1:0] man_q;
  logic [MB_W-1:0]   om_q;
  logic [TIME_W-1:0] tp_q;

  logic              accept, b_bigger, big_shift, add_zero;
  logic              sum_zero, carry, hidden, norm_finish;
  logic [EXP_W-1:0]  diff;
  logic [MW:0]       add_res;

  function automatic logic [MB_W-1:0] clamp_m(input logic [MB_W-1:0] m);
    return (m > FRAC_MB) ? FRAC_MB : m;
  endfunction

  // Fraction is left-justified under the hidden bit so every operand shares
  // the same binary point regardless of its declared precision.
  function automatic logic [MW-1:0] unpack_man(input logic [OPW-1:0] op,
                                               input logic [MB_W-1:0] m);
    logic [FRAC_W-1:0] f;
    f = op[FRAC_W-1:0] << (FRAC_MB - clamp_m(m));
    if (op[OPW-2:FRAC_W] == '0) return '0;
    return {1'b1, f, {G{1'b0}}};
  endfunction

  assign accept    = bus.in_valid && bus.in_ready;
  assign b_bigger  = {exp_b, man_b} > {exp_a, man_a};
  assign diff      = b_bigger ? (exp_b - exp_a) : (exp_a - exp_b);
  assign big_shift = int'(d) > ZERO_LIM;
  assign add_res   = (sign_a == sign_b) ? ({1'b0, man_a} + {1'b0, man_b})
                                        : ({1'b0, man_a} - {1'b0, man_b});
  assign add_zero  = (add_res == '0);
  assign sum_zero  = (sum == '0);
  assign carry     = sum[MW];
  assign hidden    = sum[MW-1];
  // Overflow and underflow are terminal: they finish without shifting.
  assign norm_finish = sum_zero ||
                       (carry ? (exp_r == EXP_MAX) : (hidden || exp_r <= EXP_ONE));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SETUP;
      SETUP:   next_state = (diff == '0) ? ADD : SHIFT;
      SHIFT:   if (big_shift || d == EXP_ONE) next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    if (norm_finish) next_state = DONE;
      DONE:    if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_a <= 1'b0; sign_b <= 1'b0; sign_r <= 1'b0;
      exp_a  <= '0;   exp_b  <= '0;   exp_r  <= '0;   d <= '0;
      man_a  <= '0;   man_b  <= '0;   sum    <= '0;
      out_m  <= '0;   cnt    <= '0;
      sign_q <= 1'b0; ovf_q  <= 1'b0; unf_q  <= 1'b0;
      exp_q  <= '0;   man_q  <= '0;   om_q   <= '0;   tp_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_a <= bus.op_a[OPW-1];
          sign_b <= bus.op_b[OPW-1] ^ bus.sub;
          exp_a  <= bus.op_a[OPW-2:FRAC_W];
          exp_b  <= bus.op_b[OPW-2:FRAC_W];
          man_a  <= unpack_man(bus.op_a, bus.m_bit_a);
          man_b  <= unpack_man(bus.op_b, bus.m_bit_b);
          out_m  <= (clamp_m(bus.m_bit_a) > clamp_m(bus.m_bit_b)) ?
                    clamp_m(bus.m_bit_a) : clamp_m(bus.m_bit_b);
          cnt    <= TIME_W'(1);
        end
        SETUP: begin
          if (b_bigger) begin
            sign_a <= sign_b; sign_b <= sign_a;
            exp_a  <= exp_b;  exp_b  <= exp_a;
            man_a  <= man_b;  man_b  <= man_a;
          end
          d <= diff;
        end
        SHIFT: begin
          if (big_shift) begin
            man_b <= '0;
            d     <= '0;
          end else begin
            man_b <= man_b >> 1;
            d     <= d - EXP_ONE;
          end
        end
        ADD: begin
          sum    <= add_res;
          sign_r <= add_zero ? 1'b0 : sign_a;
          exp_r  <= add_zero ? '0 : exp_a;
        end
        NORM: begin
          if (!norm_finish) begin
            if (carry) begin
              sum   <= sum >> 1;
              exp_r <= exp_r + EXP_ONE;
            end else begin
              sum   <= sum << 1;
              exp_r <= exp_r - EXP_ONE;
            end
          end else begin
            om_q <= out_m;
            tp_q <= cnt;
            if (!sum_zero && carry) begin
              sign_q <= sign_r;
              exp_q  <= EXP_MAX;
              man_q  <= {FRAC_W{1'b1}} >> (FRAC_MB - out_m);
              ovf_q  <= 1'b1;
              unf_q  <= 1'b0;
            end else if (!sum_zero && !hidden) begin
              sign_q <= 1'b0;
              exp_q  <= '0;
              man_q  <= '0;
              ovf_q  <= 1'b0;
              unf_q  <= 1'b1;
            end else begin
              sign_q <= sign_r;
              exp_q  <= exp_r;
              man_q  <= sum[FRAC_W+G-1:G] >> (FRAC_MB - out_m);
              ovf_q  <= 1'b0;
              unf_q  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
      // The finishing cycle is already counted by the value cnt holds in it.
      if ((state == SETUP || state == SHIFT || state == ADD || state == NORM) &&
          next_state != DONE)
        cnt <= cnt + TIME_W'(1);
    end
  end

  assign bus.in_ready      = (state == IDLE) && !rst;
  assign bus.out_valid     = (state == DONE);
  assign bus.sign_result   = sign_q;
  assign bus.result_exp    = exp_q;
  assign bus.result_man    = man_q;
  assign bus.output_m_bits = om_q;
  assign bus.result_bias   = 5'((1 << (EXP_W - 1)) - 1);
  assign bus.time_period   = tp_q;
  assign bus.overflow      = ovf_q;
  assign bus.underflow     = unf_q;

endmodule

// File: tb/tb_efp_add_seq.sv
// tb_efp_add_seq: self-checking bench for efp_add_seq at default parameters.
// Directed cases, reset/backpressure disturbances and randomized operands
// checked against an arithmetic reference model.
module tb_efp_add_seq;

  localparam int EXP_W = 4, FRAC_W = 19, MB_W = 5, TIME_W = 19, G = 2;
  localparam int OPW = 1 + EXP_W + FRAC_W;

  typedef struct {
    logic sign;
    int   exp;
    int   man;
    int   om;
    int   lat;
    logic ovf;
    logic unf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests_run = 0;
  int tests_failed = 0;

  efp_add_seq_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .MB_W(MB_W), .TIME_W(TIME_W)) bus ();

  efp_add_seq #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .MB_W(MB_W), .TIME_W(TIME_W), .G(G)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [OPW-1:0] mkOp(input bit sgn, input int e, input int f);
    return {sgn, 4'(e), 19'(f)};
  endfunction

  // Reference: exact integer significands with the hidden bit at FRAC_W+G;
  // alignment truncates, normalisation is derived from the leading-one position.
  function automatic res_t refModel(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                    input int ma, input int mb, input logic s);
    res_t r;
    int HID, mca, mcb, ea, eb, d, sc, n, k, ti;
    longint fmask, siga, sigb, tl, bal, sum, norm;
    logic sa, sb, tb;
    HID = FRAC_W + G;
    fmask = (longint'(1) << FRAC_W) - 1;
    mca = (ma > FRAC_W) ? FRAC_W : ma;
    mcb = (mb > FRAC_W) ? FRAC_W : mb;
    sa = a[OPW-1];
    sb = b[OPW-1] ^ s;
    ea = int'(a[OPW-2:FRAC_W]);
    eb = int'(b[OPW-2:FRAC_W]);
    siga = (ea == 0) ? 0 : ((longint'(1) << HID) |
           (((longint'(a[FRAC_W-1:0]) << (FRAC_W - mca)) & fmask) << G));
    sigb = (eb == 0) ? 0 : ((longint'(1) << HID) |
           (((longint'(b[FRAC_W-1:0]) << (FRAC_W - mcb)) & fmask) << G));
    if (eb > ea || (eb == ea && sigb > siga)) begin
      ti = ea; ea = eb; eb = ti;
      tl = siga; siga = sigb; sigb = tl;
      tb = sa; sa = sb; sb = tb;
    end
    d = ea - eb;
    bal = (d > HID + 1) ? 0 : (sigb >> d);
    sc = (d == 0) ? 0 : ((d > HID + 1) ? 1 : d);
    sum = (sa == sb) ? (siga + bal) : (siga - bal);
    r.om = (mca > mcb) ? mca : mcb;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    r.sign = sa;
    r.exp = ea;
    r.man = 0;
    n = 0;
    norm = sum;
    if (sum == 0) begin
      r.sign = 1'b0;
      r.exp = 0;
    end else if (sum >= (longint'(1) << (HID + 1))) begin
      if (ea == (1 << EXP_W) - 1) begin
        r.ovf = 1'b1;
        r.man = (1 << r.om) - 1;
      end else begin
        n = 1;
        r.exp = ea + 1;
        norm = sum >> 1;
      end
    end else if (sum < (longint'(1) << HID)) begin
      k = 0;
      while ((sum << k) < (longint'(1) << HID)) k++;
      if (ea - k >= 1) begin
        n = k;
        r.exp = ea - k;
        norm = sum << k;
      end else begin
        n = ea - 1;
        r.unf = 1'b1;
        r.sign = 1'b0;
        r.exp = 0;
      end
    end
    if (!r.ovf && !r.unf)
      r.man = int'(((norm >> G) & fmask) >> (FRAC_W - r.om));
    r.lat = 3 + sc + n;
    return r;
  endfunction

  task automatic applyStimulus(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                               input int ma, input int mb, input logic s);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) checkOutput("accept_timeout", 0, 1);
    bus.op_a = a;
    bus.op_b = b;
    bus.m_bit_a = MB_W'(ma);
    bus.m_bit_b = MB_W'(mb);
    bus.sub = s;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(input res_t r, input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, r.lat);
    checkOutput({tag, "_sign"}, bus.sign_result, r.sign);
    checkOutput({tag, "_exp"}, bus.result_exp, r.exp);
    checkOutput({tag, "_man"}, bus.result_man, r.man);
    checkOutput({tag, "_mbits"}, bus.output_m_bits, r.om);
    checkOutput({tag, "_time"}, bus.time_period, r.lat);
    checkOutput({tag, "_ovf"}, bus.overflow, r.ovf);
    checkOutput({tag, "_unf"}, bus.underflow, r.unf);
    checkOutput({tag, "_busy"}, bus.in_ready, 0);
  endtask

  task automatic releaseResult(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({tag, "_ovalid_clr"}, bus.out_valid, 0);
    checkOutput({tag, "_iready_set"}, bus.in_ready, 1);
  endtask

  task automatic runOne(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                        input int ma, input int mb, input logic s, input string tag);
    res_t r;
    r = refModel(a, b, ma, mb, s);
    applyStimulus(a, b, ma, mb, s);
    waitResult(r, tag);
    releaseResult(tag);
  endtask

  initial begin
    res_t r;
    int seen;
    logic [OPW-1:0] ra, rb;
    int ea, eb;

    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.m_bit_a = '0;
    bus.m_bit_b = '0;
    bus.sub = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_exp", bus.result_exp, 0);
    checkOutput("rst_man", bus.result_man, 0);
    checkOutput("rst_time", bus.time_period, 0);
    checkOutput("rst_bias", bus.result_bias, 7);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_in_ready", bus.in_ready, 1);

    // Directed cases
    runOne(mkOp(0, 7, 4), mkOp(0, 7, 0), 3, 2, 0, "add_1p5_1p0");
    runOne(mkOp(0, 9, 0), mkOp(0, 7, 0), 2, 2, 0, "add_4_1");
    runOne(mkOp(0, 7, 4), mkOp(0, 7, 4), 3, 3, 1, "sub_equal");
    runOne(mkOp(0, 15, 7), mkOp(0, 15, 7), 3, 3, 0, "overflow");
    runOne(mkOp(0, 1, 2), mkOp(0, 1, 1), 2, 2, 1, "underflow");
    runOne(mkOp(1, 5, 3), mkOp(0, 8, 1), 31, 2, 0, "mclamp_mixed_sign");
    runOne(mkOp(0, 0, 5), mkOp(1, 6, 1), 3, 3, 0, "zero_plus_neg");

    // Reset pulse while aligning: the result must never appear
    applyStimulus(mkOp(0, 15, 0), mkOp(0, 1, 0), 2, 2, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_shift_ovalid", bus.out_valid, 0);
    checkOutput("rst_shift_iready_during", bus.in_ready, 0);
    rst = 1'b0;
    #1;
    checkOutput("rst_shift_iready_after", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("rst_shift_no_result", seen, 0);

    // Backpressure: outputs hold, a busy-time in_valid is dropped
    r = refModel(mkOp(0, 7, 4), mkOp(0, 7, 0), 3, 2, 0);
    applyStimulus(mkOp(0, 7, 4), mkOp(0, 7, 0), 3, 2, 0);
    waitResult(r, "bp_first");
    @(negedge clk);
    bus.op_a = mkOp(0, 9, 0);
    bus.op_b = mkOp(0, 7, 0);
    bus.m_bit_a = MB_W'(2);
    bus.m_bit_b = MB_W'(2);
    bus.in_valid = 1'b1;
    repeat (10) @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("bp_hold_valid", bus.out_valid, 1);
    checkOutput("bp_hold_exp", bus.result_exp, r.exp);
    checkOutput("bp_hold_man", bus.result_man, r.man);
    checkOutput("bp_hold_time", bus.time_period, r.lat);
    checkOutput("bp_hold_in_ready", bus.in_ready, 0);
    releaseResult("bp");
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("bp_ignored_in_valid", seen, 0);

    // Randomized operands
    for (int i = 0; i < 150; i++) begin
      ea = $urandom_range(0, 15);
      eb = ($urandom_range(0, 2) == 0) ? ea : $urandom_range(0, 15);
      ra = mkOp($urandom_range(0, 1), ea, $urandom_range(0, (1 << FRAC_W) - 1));
      rb = mkOp($urandom_range(0, 1), eb, $urandom_range(0, (1 << FRAC_W) - 1));
      runOne(ra, rb, $urandom_range(0, 31), $urandom_range(0, 31),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
